parity_stream_checker: RTL and testbench

//   Parametrised streaming successor of the 9-bit combinational parity checker.

---
 rtl/parity_stream_checker.sv | 141 ++++++++++++++
 tb/tb_parity_stream_checker.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_checker.sv
// Streaming parity checker: per-word parity, per-frame accumulated parity
// checked against a per-frame even/odd policy, plus a saturating error count.
module parity_stream_checker #(
  parameter int DATA_W = 9,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              odd_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              word_valid,
  output logic              word_even,
  output logic              word_odd,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              frame_even,
  output logic              frame_odd,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_len,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clear_cnt
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic             policy_q, policy_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             word_valid_q, word_valid_d;
  logic             word_odd_q, word_odd_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_odd_q, frame_odd_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] frame_len_q, frame_len_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             beat, first, wpar, acc_base, pol, fodd, ferr;
  logic [CNT_W-1:0] len_next;

  assign in_ready = (state_q != HOLD);

  // Next-state, accumulator and output-register computation
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    policy_d      = policy_q;
    len_d         = len_q;
    word_valid_d  = 1'b0;
    word_odd_d    = word_odd_q;
    frame_valid_d = frame_valid_q;
    frame_odd_d   = frame_odd_q;
    frame_err_d   = frame_err_q;
    frame_len_d   = frame_len_q;
    err_count_d   = err_count_q;

    beat  = in_valid & in_ready;
    first = (state_q == IDLE);
    wpar  = ^in_data;

    // First beat of a frame restarts accumulator/length and latches the policy
    acc_base = first ? 1'b0 : acc_q;
    pol      = first ? odd_mode : policy_q;
    len_next = first ? CNT_ONE : ((len_q == CNT_MAX) ? len_q : len_q + CNT_ONE);
    fodd     = acc_base ^ wpar;
    ferr     = fodd ^ pol;

    case (state_q)
      IDLE:    if (beat) state_d = in_last ? HOLD : ACCUM;
      ACCUM:   if (beat && in_last) state_d = HOLD;
      HOLD:    if (frame_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (beat) begin
      word_valid_d = 1'b1;
      word_odd_d   = wpar;
      acc_d        = fodd;
      len_d        = len_next;
      policy_d     = pol;
      if (in_last) begin
        frame_valid_d = 1'b1;
        frame_odd_d   = fodd;
        frame_err_d   = ferr;
        frame_len_d   = len_next;
        if (ferr && (err_count_q != CNT_MAX)) err_count_d = err_count_q + CNT_ONE;
      end
    end

    if ((state_q == HOLD) && frame_ready) frame_valid_d = 1'b0;

    // Clear wins over a simultaneous increment
    if (clear_cnt) err_count_d = '0;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= 1'b0;
      policy_q      <= 1'b0;
      len_q         <= '0;
      word_valid_q  <= 1'b0;
      word_odd_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_odd_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_len_q   <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      policy_q      <= policy_d;
      len_q         <= len_d;
      word_valid_q  <= word_valid_d;
      word_odd_q    <= word_odd_d;
      frame_valid_q <= frame_valid_d;
      frame_odd_q   <= frame_odd_d;
      frame_err_q   <= frame_err_d;
      frame_len_q   <= frame_len_d;
      err_count_q   <= err_count_d;
    end
  end

  assign word_valid  = word_valid_q;
  assign word_odd    = word_odd_q;
  assign word_even   = ~word_odd_q;
  assign frame_valid = frame_valid_q;
  assign frame_odd   = frame_odd_q;
  assign frame_even  = ~frame_odd_q;
  assign frame_err   = frame_err_q;
  assign frame_len   = frame_len_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Bench for parity_stream_checker: directed cases plus random traffic
// compared every cycle against a frame-level reference model.
module tb_parity_stream_checker;
  localparam int DATA_W = 9;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, odd_mode, in_valid, in_last, frame_ready, clear_cnt;
  logic [DATA_W-1:0] in_data;
  logic in_ready, word_valid, word_even, word_odd;
  logic frame_valid, frame_even, frame_odd, frame_err;
  logic [CNT_W-1:0] frame_len, err_count;

  parity_stream_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .odd_mode(odd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .word_valid(word_valid), .word_even(word_even), .word_odd(word_odd),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_even(frame_even), .frame_odd(frame_odd), .frame_err(frame_err),
    .frame_len(frame_len), .err_count(err_count), .clear_cnt(clear_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: words of the open frame, and the last reported results
  logic [DATA_W-1:0] words[$];
  bit m_policy, m_wv, m_wodd, m_fv, m_fodd, m_ferr;
  int m_flen, m_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance model by one clock using the inputs currently applied
  task automatic model_step();
    bit beat;
    int ones;
    if (reset) begin
      words.delete();
      m_wv = 0; m_wodd = 0; m_fv = 0; m_fodd = 0; m_ferr = 0;
      m_flen = 0; m_cnt = 0; m_policy = 0;
      return;
    end
    beat = in_valid && !m_fv;
    m_wv = beat;
    if (beat) m_wodd = ($countones(in_data) % 2) == 1;
    if (m_fv && frame_ready) m_fv = 0;
    if (beat) begin
      if (words.size() == 0) m_policy = odd_mode;
      words.push_back(in_data);
      if (in_last) begin
        ones = 0;
        foreach (words[i]) ones += $countones(words[i]);
        m_fv   = 1;
        m_fodd = (ones % 2) == 1;
        m_ferr = m_fodd != m_policy;
        m_flen = (words.size() > CMAX) ? CMAX : words.size();
        if (m_ferr && m_cnt < CMAX) m_cnt++;
        words.delete();
      end
    end
    if (clear_cnt) m_cnt = 0;
  endtask

  // One clock: update model, clock the DUT, compare all outputs
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("in_ready",    32'(in_ready),    32'(!m_fv));
    chk("word_valid",  32'(word_valid),  32'(m_wv));
    chk("word_odd",    32'(word_odd),    32'(m_wodd));
    chk("word_even",   32'(word_even),   32'(!m_wodd));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("frame_odd",   32'(frame_odd),   32'(m_fodd));
    chk("frame_even",  32'(frame_even),  32'(!m_fodd));
    chk("frame_err",   32'(frame_err),   32'(m_ferr));
    chk("frame_len",   32'(frame_len),   32'(m_flen));
    chk("err_count",   32'(err_count),   32'(m_cnt));
  endtask

  task automatic idle_in();
    reset = 0; in_valid = 0; in_last = 0; in_data = '0;
    frame_ready = 0; clear_cnt = 0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic last);
    in_valid = 1; in_data = d; in_last = last;
    step();
    in_valid = 0; in_last = 0;
  endtask

  task automatic take();
    frame_ready = 1; step(); frame_ready = 0;
  endtask

  initial begin
    idle_in();
    odd_mode = 0;
    reset = 1; step(); step();
    chk("rst_word_even",  32'(word_even),  32'd1);
    chk("rst_frame_even", 32'(frame_even), 32'd1);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    reset = 0;

    // 1: single-word odd frame under even policy
    odd_mode = 0;
    send(9'h1FF, 1);
    chk("t1_word_odd",  32'(word_odd),  32'd1);
    chk("t1_frame_odd", 32'(frame_odd), 32'd1);
    chk("t1_frame_err", 32'(frame_err), 32'd1);
    chk("t1_frame_len", 32'(frame_len), 32'd1);
    chk("t1_err_count", 32'(err_count), 32'd1);
    take(); step();

    // 2: two-word frame under odd policy
    odd_mode = 1;
    send(9'h001, 0);
    send(9'h003, 1);
    chk("t2_frame_odd", 32'(frame_odd), 32'd1);
    chk("t2_frame_err", 32'(frame_err), 32'd0);
    chk("t2_frame_len", 32'(frame_len), 32'd2);
    chk("t2_err_count", 32'(err_count), 32'd1);

    // 3: backpressure from the consumer holds the result and stalls input
    in_valid = 1; in_data = 9'h0AA; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_in_ready", 32'(in_ready),  32'd0);
      chk("t3_stable",   32'(frame_len), 32'd2);
    end
    in_valid = 0; in_last = 0;
    take();
    chk("t3_fv_drop", 32'(frame_valid), 32'd0);
    chk("t3_ready",   32'(in_ready),    32'd1);

    // 4: policy change mid-frame is ignored
    odd_mode = 0;
    send(9'h000, 0);
    odd_mode = 1;
    send(9'h000, 0);
    send(9'h000, 1);
    chk("t4_frame_err", 32'(frame_err), 32'd0);
    chk("t4_frame_len", 32'(frame_len), 32'd3);
    take();

    // 5: saturation of err_count, then clear beats increment
    clear_cnt = 1; step(); clear_cnt = 0;
    odd_mode = 0;
    for (int i = 0; i < 4; i++) begin
      send(9'h001, 1);
      chk("t5_err_count", 32'(err_count), (i < 3) ? 32'(i + 1) : 32'd3);
      take();
    end
    clear_cnt = 1;
    send(9'h001, 1);
    clear_cnt = 0;
    chk("t5_clear_wins", 32'(err_count), 32'd0);
    take();

    // 6: reset mid-frame discards the partial frame
    send(9'h001, 0);
    send(9'h002, 0);
    reset = 1; step(); reset = 0;
    chk("t6_no_fv", 32'(frame_valid), 32'd0);
    step();
    send(9'h001, 1);
    chk("t6_frame_len", 32'(frame_len), 32'd1);
    chk("t6_frame_odd", 32'(frame_odd), 32'd1);
    take();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_data     = DATA_W'($urandom);
      in_last     = ($urandom_range(0, 3) == 0);
      frame_ready = ($urandom_range(0, 1) == 1);
      odd_mode    = ($urandom_range(0, 3) == 0) ? ~odd_mode : odd_mode;
      clear_cnt   = ($urandom_range(0, 49) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
